entrada_dados: RTL
==================

ENTRADA_DADOS -- requirements
Module: entrada_dados

Interface
REQ-001 The block SHALL have parameter DIGITOS, default 8, giving the number of packed BCD input digits; the legal range is 1..8.
REQ-002 clock  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-003 reset  input  1  reset SHALL be synchronous and active-low: reset==0 sampled on a rising clock edge resets the block.
REQ-004 iniciar  input  1  start request, sampled in OCIOSO only.
REQ-005 digitos  input  32  packed BCD digits, with digit 0 in bits [3:0]; bits above 4*DIGITOS-1 are ignored.
REQ-006 neg  input  1  sign of the entered value, where 1 means negative.
REQ-007 dados  output  32  two's-complement binary result.
REQ-008 pronto  output  1  one-cycle completion pulse.
REQ-009 ocupado  output  1  high while a conversion is in progress, i.e. in any state other than OCIOSO.
REQ-010 erro  output  1  invalid-BCD flag for the last completed request.

Function
REQ-011 The FSM SHALL have exactly four states: OCIOSO, VERIFICA, DESLOCA and SINAL.
REQ-012 In OCIOSO with iniciar=1, the block SHALL capture digitos (masked to 4*DIGITOS bits) into a BCD shift register, capture neg, clear the binary accumulator and go to VERIFICA.
REQ-013 In VERIFICA, if any captured nibble is greater than 9, the block SHALL set dados=0 and erro=1, pulse pronto and return to OCIOSO.
REQ-014 In VERIFICA with all nibbles valid, the block SHALL clear the shift counter and go to DESLOCA.
REQ-015 DESLOCA SHALL perform reverse double-dabble, one step per cycle: shift the {BCD register, accumulator} pair right by 1, then subtract 3 from every BCD nibble that is >= 8.
REQ-016 DESLOCA SHALL run for exactly 4*DIGITOS cycles and then go to SINAL.
REQ-017 In SINAL, the block SHALL load dados with the accumulator if neg=0, or with ~accumulator+1 if neg=1; it SHALL then set erro=0, pulse pronto and return to OCIOSO.
REQ-018 For valid input, pronto SHALL be high in the cycle after the (4*DIGITOS+3)th rising edge, counting the edge that sampled iniciar as edge 1; for DIGITOS=8 this is edge 35.
REQ-019 For invalid input, pronto SHALL be high in the cycle after edge 2.
REQ-020 pronto SHALL never be high for two consecutive cycles.
REQ-021 iniciar SHALL be ignored while ocupado=1; the captured operands SHALL stay unchanged until the conversion completes.
REQ-022 dados and erro SHALL hold their values from completion until the next completion.
REQ-023 A magnitude of zero with neg=1 SHALL produce dados=0x00000000.
REQ-024 Changes on digitos or neg after capture SHALL have no effect on the conversion in progress.
REQ-025 iniciar=1 in the same cycle that pronto is high SHALL be accepted, since the FSM is then in OCIOSO.

Reset
REQ-026 On reset, the block SHALL set the state to OCIOSO and force dados=0, pronto=0, ocupado=0 and erro=0, and clear the BCD register, accumulator and counter.
REQ-027 Reset asserted mid-conversion SHALL abort the conversion with no pronto pulse.
REQ-028 Reset SHALL take priority over iniciar.

Structure
REQ-029 A shared package SHALL hold the state enumeration, the BCD digit width (4), the data width (32) and the maximum digit count (8).
REQ-030 The per-nibble correction (subtract 3 if >= 8) SHALL be a sub-module named bcd_ajuste_nibble, instantiated DIGITOS times.
REQ-031 Everything else SHALL live in entrada_dados.

Verification
REQ-032 digitos=0x00001234, neg=0, start -> pronto after edge 35, dados=0x000004D2, erro=0.
REQ-033 digitos=0x00000042, neg=1 -> dados=0xFFFFFFD6 (-42); and digitos=0, neg=1 -> dados=0x00000000.
REQ-034 digitos=0x99999999, neg=0 -> dados=0x05F5E0FF, erro=0.
REQ-035 digitos=0x0000A000 -> pronto after edge 2, erro=1, dados=0; a following valid request -> erro returns to 0.
REQ-036 Pulse iniciar at edge 10 of a conversion with different digitos -> ignored, original result delivered; pull reset low at edge 20 -> no pronto, all outputs 0, OCIOSO.
REQ-037 Back-to-back: iniciar high in the pronto cycle -> second conversion starts immediately with correct latency and result.

Source files
------------

// File: rtl/entrada_dados_pkg.sv
// Shared types and widths for the BCD-to-binary entry block.
// Holds the FSM state encoding and the digit/data widths used by the top and the nibble corrector.
package entrada_dados_pkg;

    localparam int BCD_W       = 4;
    localparam int DADOS_W     = 32;
    localparam int MAX_DIGITOS = 8;

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        VERIFICA = 2'd1,
        DESLOCA  = 2'd2,
        SINAL    = 2'd3
    } estado_t;

    // A BCD digit is valid only in the range 0..9.
    function automatic logic nibble_invalido(input logic [BCD_W-1:0] nib);
        return nib > 4'd9;
    endfunction

endpackage

// File: rtl/entrada_dados_ajuste.sv
// Reverse double-dabble correction for one BCD digit.
// After a right shift, a digit that received a bit at its MSB (>= 8) holds 8 instead of 5, so subtract 3.
module bcd_ajuste_nibble
    import entrada_dados_pkg::*;
(
    input  logic [BCD_W-1:0] entrada,
    output logic [BCD_W-1:0] saida
);

    always_comb begin
        saida = entrada;
        if (entrada >= 4'd8)
            saida = entrada - 4'd3;
    end

endmodule

// File: rtl/entrada_dados.sv
// Converts packed BCD digits plus sign into a two's-complement word.
// Validates the digits, runs reverse double-dabble one bit per cycle, then applies the sign.
module entrada_dados
    import entrada_dados_pkg::*;
#(
    parameter int DIGITOS = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               iniciar,
    input  logic [DADOS_W-1:0] digitos,
    input  logic               neg,
    output logic [DADOS_W-1:0] dados,
    output logic               pronto,
    output logic               ocupado,
    output logic               erro
);

    localparam int BCD_BITS = BCD_W * DIGITOS;
    localparam int CNT_W    = $clog2(BCD_BITS);
    localparam int ALINHA   = DADOS_W - BCD_BITS;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(BCD_BITS - 1);

    estado_t estado, estado_prox;

    logic [BCD_BITS-1:0] bcd, bcd_desl, bcd_aj;
    logic [DADOS_W-1:0]  acc, acc_desl, magnitude, resultado;
    logic [CNT_W-1:0]    cnt;
    logic                sinal_neg;
    logic [DIGITOS-1:0]  nib_inval;
    logic                bcd_inval;

    // Datapath: one reverse double-dabble step
    assign {bcd_desl, acc_desl} = {bcd, acc} >> 1;

    for (genvar g = 0; g < DIGITOS; g++) begin : g_nib
        bcd_ajuste_nibble u_ajuste (
            .entrada (bcd_desl[g*BCD_W +: BCD_W]),
            .saida   (bcd_aj[g*BCD_W +: BCD_W])
        );
        assign nib_inval[g] = nibble_invalido(bcd[g*BCD_W +: BCD_W]);
    end

    assign bcd_inval = |nib_inval;

    // Bits enter the accumulator at the top, so with fewer than 8 digits the value is left-aligned.
    assign magnitude = acc >> ALINHA;
    assign resultado = sinal_neg ? (~magnitude + 1'b1) : magnitude;

    assign ocupado = (estado != OCIOSO);

    always_ff @(posedge clock) begin
        if (!reset)
            estado <= OCIOSO;
        else
            estado <= estado_prox;
    end

    always_comb begin
        estado_prox = estado;
        unique case (estado)
            OCIOSO:   if (iniciar) estado_prox = VERIFICA;
            VERIFICA: estado_prox = bcd_inval ? OCIOSO : DESLOCA;
            DESLOCA:  if (cnt == ULTIMO) estado_prox = SINAL;
            SINAL:    estado_prox = OCIOSO;
            default:  estado_prox = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            bcd       <= '0;
            acc       <= '0;
            cnt       <= '0;
            sinal_neg <= 1'b0;
            dados     <= '0;
            pronto    <= 1'b0;
            erro      <= 1'b0;
        end else begin
            pronto <= 1'b0;
            unique case (estado)
                OCIOSO: begin
                    if (iniciar) begin
                        bcd       <= digitos[BCD_BITS-1:0];
                        sinal_neg <= neg;
                        acc       <= '0;
                    end
                end
                VERIFICA: begin
                    if (bcd_inval) begin
                        dados  <= '0;
                        erro   <= 1'b1;
                        pronto <= 1'b1;
                    end else begin
                        cnt <= '0;
                    end
                end
                DESLOCA: begin
                    bcd <= bcd_aj;
                    acc <= acc_desl;
                    cnt <= cnt + 1'b1;
                end
                SINAL: begin
                    dados  <= resultado;
                    erro   <= 1'b0;
                    pronto <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
